uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmit engine among NREQ byte requesters.
- Accepts one byte per requester through a req/ack handshake and issues it to the engine as a start pulse with a held byte.
- Tracks the engine through busy and done, enforces a minimum idle gap between frames, and flags an engine that never starts.
- Sits between on-chip byte sources (LED/status, loopback, debug) and the UART transmitter; clk domain only.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_arb.sv | 48 ++++
 rtl/uart_tx_sched.sv | 139 +++++++++++++
 tb/tb_uart_tx_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// data/counter widths and the round-robin pointer advance helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FRAMES_W    = 16;
  localparam int ID_W        = 3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // Pointer moves to the requester just after the one granted, wrapping at nreq.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] k, input int nreq);
    if (k == ID_W'(nreq - 1)) begin
      return '0;
    end
    return k + ID_W'(1);
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping at NREQ. Produces a one-hot grant and the granted index.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            valid
);

  logic [2*NREQ-1:0] rot2;
  logic [NREQ-1:0]   rot_req;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     sum;

  // Rotating the doubled vector puts the pointer's requester at bit 0.
  assign rot2    = {req, req} >> ptr;
  assign rot_req = rot2[NREQ-1:0];

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && rot_req[i]) begin
        valid = 1'b1;
        off   = ID_W'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NREQ)) begin
      sum = sum - (ID_W + 1)'(NREQ);
    end
  end

  assign grant_idx = sum[ID_W-1:0];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant[gi] = valid && (grant_idx == ID_W'(gi));
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit engine among NREQ byte
// requesters, with a start timeout and a minimum idle gap between frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int GAP      = 2,
  parameter int START_TO = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_i,
  input  logic [NREQ-1:0]             req_i,
  input  logic [UART_DATA_W*NREQ-1:0] data_i,
  output logic [NREQ-1:0]             ack_o,
  output logic                        tx_start_o,
  output logic [UART_DATA_W-1:0]      tx_data_o,
  input  logic                        tx_busy_i,
  input  logic                        tx_done_i,
  output logic [ID_W-1:0]             grant_id_o,
  output logic                        busy_o,
  output logic                        err_o,
  input  logic                        clr_err_i,
  output logic [FRAMES_W-1:0]         frames_o
);

  localparam logic [7:0] GAP_CNT  = 8'(GAP);
  localparam logic [7:0] TO_LIMIT = 8'(START_TO);

  logic [1:0]             state_reg;
  logic [ID_W-1:0]        ptr_reg;
  logic [7:0]             to_cnt_reg;
  logic [7:0]             gap_cnt_reg;
  logic [NREQ-1:0]        ack_reg;
  logic                   start_reg;
  logic [UART_DATA_W-1:0] data_reg;
  logic [ID_W-1:0]        id_reg;
  logic                   err_reg;
  logic [FRAMES_W-1:0]    frames_reg;

  logic [NREQ-1:0]        grant_oh;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_valid;
  logic [UART_DATA_W-1:0] sel_byte;
  logic                   frame_end;

  uart_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req      (req_i),
    .ptr      (ptr_reg),
    .grant    (grant_oh),
    .grant_idx(grant_idx),
    .valid    (grant_valid)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_byte = data_i[UART_DATA_W*i +: UART_DATA_W];
      end
    end
  end

  // A done pulse while still waiting for busy counts as a completed frame.
  assign frame_end = tx_done_i && (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
      ack_reg     <= '0;
      start_reg   <= 1'b0;
      data_reg    <= '0;
      id_reg      <= '0;
      err_reg     <= 1'b0;
      frames_reg  <= '0;
    end else begin
      ack_reg   <= '0;
      start_reg <= 1'b0;
      if (clr_err_i) begin
        err_reg <= 1'b0;
      end

      if (frame_end) begin
        frames_reg  <= frames_reg + FRAMES_W'(1);
        gap_cnt_reg <= '0;
        state_reg   <= (GAP > 0) ? ST_GAP : ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (enable_i && grant_valid) begin
              data_reg   <= sel_byte;
              ack_reg    <= grant_oh;
              start_reg  <= 1'b1;
              id_reg     <= grant_idx;
              ptr_reg    <= next_ptr(grant_idx, NREQ);
              to_cnt_reg <= '0;
              state_reg  <= ST_WAIT_BUSY;
            end
          end
          ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
              state_reg <= ST_WAIT_DONE;
            end else if (to_cnt_reg + 8'd1 == TO_LIMIT) begin
              // Engine never started: the byte is lost, set wins over clear.
              err_reg   <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              to_cnt_reg <= to_cnt_reg + 8'd1;
            end
          end
          ST_WAIT_DONE: begin
            state_reg <= ST_WAIT_DONE;
          end
          default: begin
            if (gap_cnt_reg + 8'd1 == GAP_CNT) begin
              state_reg <= ST_IDLE;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign ack_o      = ack_reg;
  assign tx_start_o = start_reg;
  assign tx_data_o  = data_reg;
  assign grant_id_o = id_reg;
  assign busy_o     = (state_reg != ST_IDLE);
  assign err_o      = err_reg;
  assign frames_o   = frames_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected grants are queued as requests
// are driven and checked against each start pulse from a modelled engine.
module tb_uart_tx_sched;

  localparam int NREQ       = 4;
  localparam int GAP        = 2;
  localparam int START_TO   = 15;
  localparam int ENG_NORMAL = 0;
  localparam int ENG_FAST   = 1;
  localparam int ENG_NEVER  = 2;

  logic              clk;
  logic              rst;
  logic              enable_i;
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] data_i;
  logic [NREQ-1:0]   ack_o;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_busy_i;
  logic              tx_done_i;
  logic [2:0]        grant_id_o;
  logic              busy_o;
  logic              err_o;
  logic              clr_err_i;
  logic [15:0]       frames_o;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   eng_mode = ENG_NORMAL;
  int   eng_cnt  = 0;
  int   ack_seen;

  uart_tx_sched #(
    .NREQ(NREQ), .GAP(GAP), .START_TO(START_TO)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .grant_id_o(grant_id_o),
    .busy_o(busy_o), .err_o(err_o), .clr_err_i(clr_err_i), .frames_o(frames_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 3'(id);
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = tx_start_o;
    end
    if (!seen) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int exp);
    for (int k = 0; k < 100 && frames_o != 16'(exp); k++) begin
      @(negedge clk);
    end
    check_eq(tag, 32'(frames_o), 32'(exp));
  endtask

  // Called on the first negedge after the done edge: busy for GAP cycles, then idle.
  task automatic gap_check(input string tag);
    for (int k = 0; k < GAP; k++) begin
      check_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
      @(negedge clk);
    end
    check_eq({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  // Engine model: busy one cycle after start, done ten cycles later (normal);
  // done together with busy on the cycle after start (fast); silent (never).
  always @(negedge clk) begin
    if (!rst) begin
      eng_cnt   = 0;
      tx_busy_i = 1'b0;
      tx_done_i = 1'b0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        tx_done_i = (eng_cnt == 0);
        tx_busy_i = (eng_cnt != 0) || (eng_mode == ENG_FAST);
      end else begin
        tx_done_i = 1'b0;
        tx_busy_i = 1'b0;
      end
      if (tx_start_o) begin
        if (eng_mode == ENG_NORMAL) eng_cnt = 11;
        else if (eng_mode == ENG_FAST) eng_cnt = 1;
      end
    end
  end

  // Scoreboard consumer: every start pulse must match the next queued grant.
  always @(negedge clk) begin
    if (rst && tx_start_o) begin
      $display("txn: start id=%0d data=0x%02h ack=%b frames=%0d", grant_id_o, tx_data_o, ack_o, frames_o);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_start", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_grant_id", 32'(grant_id_o), 32'(mon_e.id));
        check_eq("sb_tx_data", 32'(tx_data_o), 32'(mon_e.data));
        check_eq("sb_ack", 32'(ack_o), 32'(1) << mon_e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    enable_i  = 1'b1;
    req_i     = '0;
    data_i    = '0;
    clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack_o), 32'd0);
    check_eq("rst_start", 32'(tx_start_o), 32'd0);
    check_eq("rst_data", 32'(tx_data_o), 32'd0);
    check_eq("rst_grant", 32'(grant_id_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_frames", 32'(frames_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request
    data_i[7:0] = 8'h5A;
    push_exp(0, 8'h5A);
    req_i = 4'b0001;
    @(negedge clk);
    check_eq("single_ack", 32'(ack_o), 32'h1);
    check_eq("single_start", 32'(tx_start_o), 32'd1);
    check_eq("single_busy", 32'(busy_o), 32'd1);
    req_i = '0;
    @(negedge clk);
    check_eq("single_start_pulse", 32'(tx_start_o), 32'd0);
    check_eq("single_ack_pulse", 32'(ack_o), 32'd0);
    wait_frames("single_frames", 1);
    check_eq("single_data_held", 32'(tx_data_o), 32'h5A);
    gap_check("single_gap");

    // Reset in the middle of a frame
    data_i[7:0] = 8'h77;
    push_exp(0, 8'h77);
    req_i = 4'b0001;
    wait_start("midrst_start_timeout");
    req_i = '0;
    repeat (4) @(negedge clk);
    check_eq("midrst_in_frame", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_data", 32'(tx_data_o), 32'd0);
    check_eq("midrst_frames", 32'(frames_o), 32'd0);
    check_eq("midrst_ack", 32'(ack_o), 32'd0);
    check_eq("midrst_start", 32'(tx_start_o), 32'd0);
    check_eq("midrst_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_frame", 32'(frames_o), 32'd0);

    // Round robin with all requesters active
    data_i = 32'h44332211;
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(2, 8'h33);
    push_exp(3, 8'h44);
    push_exp(0, 8'h11);
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_start("rr_start_timeout");
    end
    req_i = '0;
    wait_frames("rr_frames", 5);

    // Fast engine: done with busy right after start
    eng_mode = ENG_FAST;
    data_i[15:8] = 8'hA1;
    push_exp(1, 8'hA1);
    req_i = 4'b0010;
    wait_start("fast_start_timeout");
    req_i = '0;
    wait_frames("fast_frames", 6);
    check_eq("fast_err", 32'(err_o), 32'd0);
    gap_check("fast_gap");

    // Start timeout: engine never goes busy
    eng_mode = ENG_NEVER;
    data_i[23:16] = 8'hC3;
    push_exp(2, 8'hC3);
    req_i = 4'b0100;
    wait_start("to_start_timeout");
    req_i = '0;
    repeat (START_TO - 1) @(negedge clk);
    check_eq("to_err_early", 32'(err_o), 32'd0);
    check_eq("to_busy_early", 32'(busy_o), 32'd1);
    @(negedge clk);
    check_eq("to_err_set", 32'(err_o), 32'd1);
    check_eq("to_idle", 32'(busy_o), 32'd0);
    check_eq("to_frames", 32'(frames_o), 32'd6);
    repeat (3) @(negedge clk);
    check_eq("to_err_sticky", 32'(err_o), 32'd1);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    check_eq("to_err_clr", 32'(err_o), 32'd0);

    // enable_i dropped mid-frame with another request pending
    eng_mode = ENG_NORMAL;
    data_i[31:24] = 8'hE4;
    push_exp(3, 8'hE4);
    req_i = 4'b1000;
    wait_start("en_start_timeout");
    req_i = '0;
    repeat (3) @(negedge clk);
    enable_i = 1'b0;
    data_i[15:8] = 8'hB5;
    req_i = 4'b0010;
    wait_frames("en_frames", 7);
    ack_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_o != '0) ack_seen++;
    end
    check_eq("en_no_ack", 32'(ack_seen), 32'd0);
    check_eq("en_idle", 32'(busy_o), 32'd0);
    push_exp(1, 8'hB5);
    enable_i = 1'b1;
    @(negedge clk);
    check_eq("en_ack", 32'(ack_o), 32'h2);
    check_eq("en_start", 32'(tx_start_o), 32'd1);
    req_i = '0;
    wait_frames("en_frames2", 8);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
